// File: rtl/cla_seq_adder_if.sv
// Operand/result bundle for the sequential carry-lookahead adder.
// The requester owns start/operands; the adder owns status and results.
interface cla_seq_adder_if #(parameter int WIDTH = 16);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             g_out;
    logic             p_out;

    modport master (
        output start, a, b, cin, sub,
        input  busy, done, sum, cout, ovf, g_out, p_out
    );

    modport slave (
        input  start, a, b, cin, sub,
        output busy, done, sum, cout, ovf, g_out, p_out
    );
endinterface

// File: rtl/cla_seq_adder.sv
// Sequential adder/subtractor: one 4-bit carry-lookahead slice reused over
// WIDTH/4 cycles, LSB slice first, with whole-word group generate/propagate.
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | one slice per edge, busy=1
//   DONE  | results valid, done=1 for this cycle; start here restarts
module cla_seq_adder #(
    parameter int WIDTH = 16
) (
    input logic            clk,
    input logic            rst,
    cla_seq_adder_if.slave bus
);
    localparam int NSL = WIDTH / 4;
    localparam int IW  = (NSL > 1) ? $clog2(NSL) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, sum_w, sum_q;
    logic             carry_q, g_acc, p_acc;
    logic [IW-1:0]    idx_q;
    logic             cout_q, ovf_q, g_q, p_q;

    logic [3:0] sg, sp, ss;
    logic [4:0] c;
    logic       grp_g, grp_p, accept, last;

    // Operands are shifted right each slice so the active nibble is always [3:0].
    always_comb begin
        sg = a_q[3:0] & b_q[3:0];
        sp = a_q[3:0] ^ b_q[3:0];
        c[0] = carry_q;
        c[1] = sg[0] | (sp[0] & c[0]);
        c[2] = sg[1] | (sp[1] & sg[0]) | (sp[1] & sp[0] & c[0]);
        c[3] = sg[2] | (sp[2] & sg[1]) | (sp[2] & sp[1] & sg[0])
             | (sp[2] & sp[1] & sp[0] & c[0]);
        c[4] = sg[3] | (sp[3] & sg[2]) | (sp[3] & sp[2] & sg[1])
             | (sp[3] & sp[2] & sp[1] & sg[0])
             | (sp[3] & sp[2] & sp[1] & sp[0] & c[0]);
        ss    = sp ^ c[3:0];
        grp_g = sg[3] | (sp[3] & sg[2]) | (sp[3] & sp[2] & sg[1])
              | (sp[3] & sp[2] & sp[1] & sg[0]);
        grp_p = &sp;
    end

    assign accept = bus.start && (state_q != RUN);
    assign last   = (state_q == RUN) && (idx_q == IW'(NSL - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (last)      state_d = DONE;
            DONE:    state_d = bus.start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_w   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            g_acc   <= 1'b0;
            p_acc   <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            g_q     <= 1'b0;
            p_q     <= 1'b0;
        end else if (accept) begin
            a_q     <= bus.a;
            b_q     <= bus.sub ? ~bus.b : bus.b;
            carry_q <= bus.sub ? 1'b1 : bus.cin;
            idx_q   <= '0;
            g_acc   <= 1'b0;
            p_acc   <= 1'b1;
        end else if (state_q == RUN) begin
            a_q     <= a_q >> 4;
            b_q     <= b_q >> 4;
            sum_w   <= {ss, sum_w[WIDTH-1:4]};
            carry_q <= c[4];
            idx_q   <= idx_q + IW'(1);
            g_acc   <= grp_g | (grp_p & g_acc);
            p_acc   <= grp_p & p_acc;
            if (last) begin
                sum_q  <= {ss, sum_w[WIDTH-1:4]};
                cout_q <= c[4];
                ovf_q  <= c[3] ^ c[4];
                g_q    <= grp_g | (grp_p & g_acc);
                p_q    <= grp_p & p_acc;
            end
        end
    end

    assign bus.busy  = (state_q == RUN);
    assign bus.done  = (state_q == DONE);
    assign bus.sum   = sum_q;
    assign bus.cout  = cout_q;
    assign bus.ovf   = ovf_q;
    assign bus.g_out = g_q;
    assign bus.p_out = p_q;
endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed bench for cla_seq_adder: hand-computed vectors, handshake,
// back-to-back restart and reset abort.
module tb_cla_seq_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   lat;

    cla_seq_adder_if #(.WIDTH(16)) ifc ();
    cla_seq_adder #(.WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(ifc));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation and return the number of edges after acceptance until done.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                          input logic ts, output int n);
        ifc.a = ta; ifc.b = tb_; ifc.cin = tc; ifc.sub = ts; ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
        n = 0;
        while (!ifc.done && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, {31'd0, ifc.busy}, 32'd0);
        check({tag, "_done"}, {31'd0, ifc.done}, 32'd0);
        check({tag, "_sum"},  {16'd0, ifc.sum}, 32'h0);
        check({tag, "_flags"}, {28'd0, ifc.cout, ifc.ovf, ifc.g_out, ifc.p_out}, 32'h0);
    endtask

    initial begin
        ifc.start = 1'b0; ifc.a = '0; ifc.b = '0; ifc.cin = 1'b0; ifc.sub = 1'b0;
        repeat (2) tick();
        check_zero("reset");
        rst = 1'b0;

        // plain add, started on first edge after reset release
        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, lat);
        check("add_lat", lat, 4);
        check("add_sum", {16'd0, ifc.sum}, 32'h5555);
        check("add_flags", {28'd0, ifc.cout, ifc.ovf, ifc.g_out, ifc.p_out}, 32'h0);
        tick();
        check("add_done_width", {31'd0, ifc.done}, 32'd0);
        check("add_hold", {16'd0, ifc.sum}, 32'h5555);

        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
        check("carry_lat", lat, 4);
        check("carry_sum", {16'd0, ifc.sum}, 32'h0);
        check("carry_flags", {28'd0, ifc.cout, ifc.ovf, ifc.g_out, ifc.p_out}, 32'b1010);
        tick();

        run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, lat);
        check("prop_sum", {16'd0, ifc.sum}, 32'h0);
        check("prop_flags", {28'd0, ifc.cout, ifc.ovf, ifc.g_out, ifc.p_out}, 32'b1001);
        tick();

        run_op(16'h8000, 16'h0001, 1'b1, 1'b1, lat);
        check("sub_lat", lat, 4);
        check("sub_sum", {16'd0, ifc.sum}, 32'h7FFF);
        check("sub_cout_ovf", {30'd0, ifc.cout, ifc.ovf}, 32'b11);
        tick();

        run_op(16'h0003, 16'h0005, 1'b0, 1'b1, lat);
        check("borrow_sum", {16'd0, ifc.sum}, 32'hFFFE);
        check("borrow_cout", {31'd0, ifc.cout}, 32'd0);
        tick();

        // start held through RUN with operands changing: must be ignored
        ifc.a = 16'h0100; ifc.b = 16'h0023; ifc.cin = 1'b1; ifc.sub = 1'b0; ifc.start = 1'b1;
        tick();
        ifc.a = 16'hAAAA; ifc.b = 16'h5555; ifc.sub = 1'b1;
        check("hold_busy", {31'd0, ifc.busy}, 32'd1);
        repeat (3) tick();
        check("hold_still_busy", {31'd0, ifc.busy}, 32'd1);
        ifc.start = 1'b0;
        tick();
        check("hold_done", {30'd0, ifc.done, ifc.busy}, 32'b10);
        check("hold_sum", {16'd0, ifc.sum}, 32'h0124);

        // back-to-back restart from DONE
        ifc.a = 16'h0001; ifc.b = 16'h0001; ifc.cin = 1'b0; ifc.sub = 1'b0; ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
        check("b2b_busy", {30'd0, ifc.done, ifc.busy}, 32'b01);
        repeat (3) tick();
        check("b2b_not_yet", {31'd0, ifc.done}, 32'd0);
        tick();
        check("b2b_done", {31'd0, ifc.done}, 32'd1);
        check("b2b_sum", {16'd0, ifc.sum}, 32'h0002);
        tick();
        check("b2b_idle", {30'd0, ifc.done, ifc.busy}, 32'b00);

        // abort mid-run
        ifc.a = 16'h1111; ifc.b = 16'h2222; ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        #2;
        check_zero("abort");
        tick();
        rst = 1'b0;
        lat = 0;
        repeat (6) begin
            tick();
            if (ifc.done) lat++;
        end
        check("abort_no_done", lat, 0);
        check("abort_sum_held", {16'd0, ifc.sum}, 32'h0);

        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, lat);
        check("fresh_lat", lat, 4);
        check("fresh_sum", {16'd0, ifc.sum}, 32'h0100);
        check("fresh_cout", {31'd0, ifc.cout}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cla_seq_adder.md
CLA_SEQ_ADDER -- requirements
Module: cla_seq_adder

Interface
REQ-001 SHALL have parameter: WIDTH, 16, operand width in bits; a multiple of 4 and at least 8.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset; asynchronous and active-high.
REQ-004 SHALL have port: start  input  1  request a new operation.
REQ-005 SHALL have port: a  input  WIDTH  operand A.
REQ-006 SHALL have port: b  input  WIDTH  operand B.
REQ-007 SHALL have port: cin  input  1  carry-in; ignored when sub=1.
REQ-008 SHALL have port: sub  input  1  1 selects A-B; 0 selects A+B+cin.
REQ-009 SHALL have port: busy  output  1  high while slices are being computed.
REQ-010 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port: sum  output  WIDTH  registered result.
REQ-012 SHALL have port: cout  output  1  carry out of the MSB slice.
REQ-013 SHALL have port: ovf  output  1  signed overflow.
REQ-014 SHALL have port: g_out  output  1  whole-word group generate.
REQ-015 SHALL have port: p_out  output  1  whole-word group propagate.

Function
REQ-016 SHALL contain exactly one 4-bit carry-lookahead slice, reused over WIDTH/4 cycles, LSB slice first.
- Per bit: g_i = a_i & b'_i and p_i = a_i ^ b'_i, where b' = sub ? ~b : b.
- Carries: c1..c4 from the lookahead equations on g0..g3, p0..p3 and the slice carry-in.
- Sum bit: s_i = p_i ^ c_i.
- Slice group terms: G = g3 | p3g2 | p3p2g1 | p3p2p1g0; P = p3&p2&p1&p0.
REQ-017 SHALL implement a three-state FSM: IDLE, RUN, DONE.
- IDLE --start--> RUN
- RUN --last slice--> DONE
- DONE --start--> RUN
- DONE --no start--> IDLE
REQ-018 SHALL latch a, b', the initial carry (sub ? 1 : cin) and sub on the edge that accepts start, and SHALL clear the slice index to 0 on that edge.
REQ-019 SHALL accept start only in IDLE or DONE; start in RUN SHALL be ignored, with no effect on latched operands.
REQ-020 SHALL process one slice per RUN edge, writing 4 bits into a working sum register and the slice c4 into the carry register.
REQ-021 SHALL accumulate group terms per slice:
- G_acc <= G | (P & G_acc), with G_acc starting at 0.
- P_acc <= P & P_acc, with P_acc starting at 1.
REQ-022 SHALL set busy=1 exactly in RUN, and done=1 exactly in DONE.
REQ-023 SHALL have a latency from the start-accepting edge T to the DONE-entering edge of WIDTH/4 edges (T+4 for WIDTH=16).
REQ-024 SHALL update sum, cout, g_out and p_out on the DONE-entering edge, and hold them until the next completion.
REQ-025 SHALL compute ovf = carry into MSB XOR cout of the final slice.
REQ-026 SHALL treat cout as "no borrow" when sub=1: cout=1 when A>=B unsigned.
REQ-027 SHALL support back-to-back operation: start in DONE begins a new RUN on the next edge, with no IDLE cycle.
REQ-028 SHALL change no input-visible behaviour when a, b, cin or sub change during RUN.

Reset
REQ-029 SHALL, while rst=1, force:
- state to IDLE
- busy=0, done=0
- sum=0, cout=0, ovf=0, g_out=0, p_out=0
- internal carry, slice index and accumulators to 0.
REQ-030 SHALL on reset during RUN abort the operation: no done pulse, and outputs zeroed.
REQ-031 SHALL accept start on the first rising edge after rst deasserts.

Verification
REQ-032 SHALL cover reset: rst=1 mid-stream -> busy=0, done=0, sum=0x0000, cout=0, ovf=0, g_out=0, p_out=0.
REQ-033 SHALL cover plain add: a=0x1234, b=0x4321, cin=0, sub=0 -> done at T+4, sum=0x5555, cout=0, ovf=0, g_out=0, p_out=0.
REQ-034 SHALL cover carry and propagate:
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0, g_out=1, p_out=0.
- a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, g_out=0, p_out=1.
REQ-035 SHALL cover subtract with overflow: a=0x8000, b=0x0001, sub=1, cin=1 -> sum=0x7FFF, cout=1, ovf=1.
REQ-036 SHALL cover handshake:
- start held high through RUN -> ignored; done exactly 1 cycle.
- start in DONE with a=0x0001, b=0x0001 -> busy next cycle; sum=0x0002 four edges later.
REQ-037 SHALL cover abort: rst pulse after 2 RUN edges -> no done, outputs zero; a fresh start then completes correctly.
